// File: rtl/sub32_pipe.sv
// Two-stage pipelined subtractor {bout, diff} = A - B - bin with valid/ready on both sides.
// Stage 1 resolves the low half and its borrow; stage 2 carry-selects the high half and forms flags.
module sub32_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  logic            s1_valid_r;
  logic [LO_W-1:0] d_lo_r;
  logic            b_lo_r;
  logic [HI_W-1:0] a_hi_r;
  logic [HI_W-1:0] b_hi_r;
  logic            a_msb_r;
  logic            b_msb_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             neg_r;

  logic             s2_adv_s;
  logic             s1_adv_s;
  logic [LO_W:0]    lo_s;
  logic [HI_W:0]    hi0_s;
  logic [HI_W:0]    hi1_s;
  logic [HI_W:0]    hi_sel_s;
  logic [WIDTH-1:0] diff_s;
  logic             ovf_s;
  logic             zero_s;

  // Advance control and stage-1 low-half subtraction (borrow lands in the extra MSB).
  always_comb begin
    s2_adv_s = !s2_valid_r || out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
    lo_s     = {1'b0, A[LO_W-1:0]} - {1'b0, B[LO_W-1:0]} - {{LO_W{1'b0}}, bin};
  end

  // Stage-2 high half: both borrow-in cases precomputed, low borrow picks one.
  always_comb begin
    hi0_s = {1'b0, a_hi_r} - {1'b0, b_hi_r};
    hi1_s = {1'b0, a_hi_r} - {1'b0, b_hi_r} - {{HI_W{1'b0}}, 1'b1};
    if (b_lo_r) begin
      hi_sel_s = hi1_s;
    end else begin
      hi_sel_s = hi0_s;
    end
    diff_s = {hi_sel_s[HI_W-1:0], d_lo_r};
    ovf_s  = (a_msb_r != b_msb_r) && (diff_s[WIDTH-1] != a_msb_r);
    zero_s = (diff_s == {WIDTH{1'b0}});
  end

  // Stage-1 register: captures operands on accept, drains when the next stage takes its content.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      d_lo_r     <= {LO_W{1'b0}};
      b_lo_r     <= 1'b0;
      a_hi_r     <= {HI_W{1'b0}};
      b_hi_r     <= {HI_W{1'b0}};
      a_msb_r    <= 1'b0;
      b_msb_r    <= 1'b0;
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        d_lo_r  <= lo_s[LO_W-1:0];
        b_lo_r  <= lo_s[LO_W];
        a_hi_r  <= A[WIDTH-1:LO_W];
        b_hi_r  <= B[WIDTH-1:LO_W];
        a_msb_r <= A[WIDTH-1];
        b_msb_r <= B[WIDTH-1];
      end
    end
  end

  // Stage-2 / output register: result and flags only change when the sink can take them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      diff_r     <= {WIDTH{1'b0}};
      bout_r     <= 1'b0;
      ovf_r      <= 1'b0;
      zero_r     <= 1'b0;
      neg_r      <= 1'b0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        diff_r <= diff_s;
        bout_r <= hi_sel_s[HI_W];
        ovf_r  <= ovf_s;
        zero_r <= zero_s;
        neg_r  <= diff_s[WIDTH-1];
      end
    end
  end

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;
  assign diff      = diff_r;
  assign bout      = bout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign neg       = neg_r;

endmodule

// File: tb/tb_sub32_pipe.sv
// Self-checking bench for sub32_pipe: directed vectors, backpressure, mid-flight reset and
// a randomized run against an arithmetic reference model with an in-order expectation queue.
module tb_sub32_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;
  logic        neg;

  int pass_cnt;
  int total_cnt;

  logic [35:0] exp_q[$];

  sub32_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero), .neg(neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: packed {ovf, zero, neg, bout, diff} from plain wide integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    logic [32:0] full;
    longint      sd;
    logic        o;
    full = {1'b0, a} - {1'b0, b} - {32'd0, bi};
    sd   = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    o    = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {o, (full[31:0] == 32'd0), full[31], full[32], full[31:0]};
  endfunction

  function automatic logic [35:0] observed();
    return {ovf, zero, neg, bout, diff};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 32'd0; B = 32'd0; bin = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if ({out_valid, observed()} !== 37'd0) $display("FAIL reset_outputs: got %h want 0", {out_valid, observed()});
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ta[7] = '{32'h0000_0005, 32'h0001_0000, 32'h0000_0000, 32'h8000_0000,
                           32'h7FFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
    logic [31:0] tb[7] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
                           32'hFFFF_FFFF, 32'h1234_5678, 32'hDEAD_BEEF};
    logic        tc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    // expected {ovf, zero, neg, bout, diff} written out by hand
    logic [35:0] te[7] = '{{4'b0000, 32'h0000_0002}, {4'b0000, 32'h0000_FFFF},
                           {4'b0011, 32'hFFFF_FFFF}, {4'b1000, 32'h7FFF_FFFF},
                           {4'b1011, 32'h8000_0000}, {4'b0100, 32'h0000_0000},
                           {4'b0011, 32'hFFFF_FFFF}};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = ta[i]; B = tb[i]; bin = tc[i]; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL dir%0d_latency1: out_valid %b want 0", i, out_valid);
      else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL dir%0d_latency2: out_valid %b want 1", i, out_valid);
      else pass_cnt++;
      total_cnt++;
      if (observed() !== te[i]) $display("FAIL dir%0d_result: got %h want %h", i, observed(), te[i]);
      else pass_cnt++;
      total_cnt++;
      if (model(ta[i], tb[i], tc[i]) !== te[i]) $display("FAIL dir%0d_model: got %h want %h", i, model(ta[i], tb[i], tc[i]), te[i]);
      else pass_cnt++;
      @(negedge clk);
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL dir%0d_drain: out_valid %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ba[4];
    logic [31:0] bb[4];
    logic [35:0] held;
    int          acc;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      ba[i] = $urandom(); bb[i] = $urandom();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = ba[i]; B = bb[i]; bin = 1'b0; out_ready = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== (i < 2)) $display("FAIL bp_in_ready%0d: got %b want %b", i, in_ready, (i < 2));
      else pass_cnt++;
      if (in_ready) acc++;
      if (i == 2) held = observed();
      if (i == 3) begin
        total_cnt++;
        if (observed() !== held || out_valid !== 1'b1) $display("FAIL bp_frozen: got %h/%b want %h/1", observed(), out_valid, held);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (acc != 2) $display("FAIL bp_accepted: got %0d want 2", acc);
    else pass_cnt++;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      total_cnt++;
      if (out_valid !== 1'b1 || observed() !== model(ba[i], bb[i], 1'b0))
        $display("FAIL bp_out%0d: got %b/%h want 1/%h", i, out_valid, observed(), model(ba[i], bb[i], 1'b0));
      else pass_cnt++;
      @(negedge clk);
      #1;
    end
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL bp_empty: out_valid %b want 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1; A = $urandom(); B = $urandom(); bin = 1'b1; out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL mid_full: out_valid %b want 1", out_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, observed()} !== 37'd0 || in_ready !== 1'b1)
      $display("FAIL mid_async_clear: got %h ready %b want 0 ready 1", {out_valid, observed()}, in_ready);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL mid_stale%0d: out_valid %b want 0", i, out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int issued;
    int received;
    int cycles;
    logic [35:0] e;
    issued = 0; received = 0; cycles = 0;
    exp_q.delete();
    while ((issued < 10000 || exp_q.size() != 0) && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      in_valid  = (issued < 10000) && ($urandom_range(0, 3) != 0);
      A         = $urandom();
      B         = ($urandom_range(0, 7) == 0) ? A : $urandom();
      bin       = $urandom_range(0, 1) == 1;
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      if (out_valid && out_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rnd_extra: unexpected result %h", observed());
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) $display("FAIL rnd_result%0d: got %h want %h", received, observed(), e);
          else pass_cnt++;
        end
        received++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, bin));
        issued++;
      end
    end
    in_valid = 1'b0;
    total_cnt++;
    if (received != 10000 || exp_q.size() != 0)
      $display("FAIL rnd_count: received %0d pending %0d want 10000/0", received, exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
